// File: rtl/mem_stage_if.sv
// mem_stage_if: exe -> mem -> wb pipeline handshake plus data-SRAM response signals.
//   master : view used by mem_stage (drives ms_* outputs, samples exe/wb/sram inputs)
//   slave  : view used by the surrounding pipeline / environment
// Ports carried:
//   es_to_ms_valid, es_to_ms_bus        exe -> mem instruction handshake
//   ms_allowin                          mem -> exe back-pressure
//   ms_to_ws_valid, ms_to_ws_bus        mem -> wb completed instruction
//   ws_allowin, ws_flush_pipe           wb -> mem back-pressure and flush
//   data_sram_data_ok, data_sram_rdata  data memory response
//   ms_mem_pending                      mem -> exe: discarded request still outstanding
//   ms_to_ds_fwd                        mem -> decode forwarding (only with MS_FWD_EN)
// Optional feature macro: MS_FWD_EN.
interface mem_stage_if #(
  parameter int unsigned PAYLOAD_WD = 150
);
  localparam int unsigned ES_BUS_WD = PAYLOAD_WD + 74;
  localparam int unsigned WS_BUS_WD = PAYLOAD_WD + 70;

  logic                 es_to_ms_valid;
  logic                 ms_allowin;
  logic [ES_BUS_WD-1:0] es_to_ms_bus;
  logic                 ws_allowin;
  logic                 ms_to_ws_valid;
  logic [WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 ws_flush_pipe;
  logic                 ms_mem_pending;
`ifdef MS_FWD_EN
  logic [38:0]          ms_to_ds_fwd;
`endif

  modport master (
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  ws_allowin,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    input  ws_flush_pipe,
`ifdef MS_FWD_EN
    output ms_to_ds_fwd,
`endif
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_mem_pending
  );

  modport slave (
    output es_to_ms_valid,
    output es_to_ms_bus,
    output ws_allowin,
    output data_sram_data_ok,
    output data_sram_rdata,
    output ws_flush_pipe,
`ifdef MS_FWD_EN
    input  ms_to_ds_fwd,
`endif
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_mem_pending
  );

endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Holds one instruction from exe, waits for the
// data-SRAM response of loads/stores, extends load data and hands the result to wb.
// A small FSM tracks the outstanding response so that a flushed instruction's response
// is swallowed instead of being matched to a later request.
// Ports:
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset
//   ms_if   mem_stage_if.master (exe/wb handshakes, SRAM response, flush, pending flag)
// Optional feature macro: MS_FWD_EN adds ms_to_ds_fwd = {blocking, fwd_we, dest, final_result}.
module mem_stage #(
  parameter int unsigned PAYLOAD_WD = 150
) (
  input  logic         clk,
  input  logic         resetn,
  mem_stage_if.master  ms_if
);

  localparam int unsigned ES_BUS_WD   = PAYLOAD_WD + 74;
  localparam int unsigned WS_BUS_WD   = PAYLOAD_WD + 70;
  localparam int unsigned MEM_REQ_BIT = 73;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HAVE   = 2'd2,
    S_CANCEL = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic                 ms_valid_q, ms_valid_d;
  logic [ES_BUS_WD-1:0] es_bus_q,   es_bus_d;
  logic [31:0]          buf_data_q, buf_data_d;

  // Fields of the held instruction
  logic [PAYLOAD_WD-1:0] payload;
  logic                  mem_req;
  logic [2:0]            ld_op;
  logic                  gr_we;
  logic [4:0]            dest;
  logic [31:0]           alu_result;
  logic [31:0]           pc;

  assign {payload, mem_req, ld_op, gr_we, dest, alu_result, pc} = es_bus_q;

  logic        ms_ready_go_c;
  logic        ms_allowin_c;
  logic        accept_c;
  logic        new_mem_req_c;
  logic [31:0] raw_data_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_ext_c;
  logic [31:0] final_result_c;

  // Handshake: response present now or already buffered lets the instruction leave
  assign ms_ready_go_c = !mem_req || ms_if.data_sram_data_ok || (state_q == S_HAVE);
  assign ms_allowin_c  = (state_q != S_CANCEL) &&
                         (!ms_valid_q || (ms_ready_go_c && ms_if.ws_allowin));
  assign accept_c      = ms_if.es_to_ms_valid && ms_allowin_c;
  assign new_mem_req_c = ms_if.es_to_ms_bus[MEM_REQ_BIT];

  // Load data lane selection and extension
  always_comb begin
    raw_data_c = (state_q == S_HAVE) ? buf_data_q : ms_if.data_sram_rdata;
    case (alu_result[1:0])
      2'd0:    byte_c = raw_data_c[7:0];
      2'd1:    byte_c = raw_data_c[15:8];
      2'd2:    byte_c = raw_data_c[23:16];
      default: byte_c = raw_data_c[31:24];
    endcase
    // Misaligned halves never reach here; bit 0 is ignored on purpose
    half_c = alu_result[1] ? raw_data_c[31:16] : raw_data_c[15:0];
    case (ld_op)
      3'b001:  load_ext_c = {{24{byte_c[7]}}, byte_c};
      3'b010:  load_ext_c = {{16{half_c[15]}}, half_c};
      3'b011:  load_ext_c = {24'd0, byte_c};
      3'b100:  load_ext_c = {16'd0, half_c};
      default: load_ext_c = raw_data_c;
    endcase
    final_result_c = (mem_req && gr_we) ? load_ext_c : alu_result;
  end

  // Next-state: response-tracking FSM, instruction slot and response buffer
  always_comb begin
    state_d    = state_q;
    ms_valid_d = ms_valid_q;
    es_bus_d   = es_bus_q;
    buf_data_d = buf_data_q;

    if (ms_allowin_c) begin
      ms_valid_d = ms_if.es_to_ms_valid;
    end
    if (accept_c) begin
      es_bus_d = ms_if.es_to_ms_bus;
    end

    // A slot that empties and refills in one cycle goes straight back to WAIT
    case (state_q)
      S_IDLE: begin
        if (accept_c && new_mem_req_c) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ms_if.data_sram_data_ok) begin
          if (ms_if.ws_allowin) begin
            state_d = (accept_c && new_mem_req_c) ? S_WAIT : S_IDLE;
          end else begin
            state_d    = S_HAVE;
            buf_data_d = ms_if.data_sram_rdata;
          end
        end
      end
      S_HAVE: begin
        if (ms_if.ws_allowin) begin
          state_d = (accept_c && new_mem_req_c) ? S_WAIT : S_IDLE;
        end
      end
      S_CANCEL: begin
        if (ms_if.data_sram_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush kills the held instruction. An unanswered request (WAIT, or an already
    // cancelled one) keeps the FSM in CANCEL so its late response cannot be taken
    // by a younger request; everything else, including a buffered response, is dropped.
    if (ms_if.ws_flush_pipe) begin
      ms_valid_d = 1'b0;
      if (((state_q == S_WAIT) || (state_q == S_CANCEL)) && !ms_if.data_sram_data_ok) begin
        state_d = S_CANCEL;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ms_valid_q <= 1'b0;
      es_bus_q   <= '0;
      buf_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      ms_valid_q <= ms_valid_d;
      es_bus_q   <= es_bus_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign ms_if.ms_allowin     = ms_allowin_c;
  assign ms_if.ms_to_ws_valid = ms_valid_q && ms_ready_go_c && !ms_if.ws_flush_pipe;
  assign ms_if.ms_to_ws_bus   = WS_BUS_WD'({payload, gr_we, dest, final_result_c, pc});
  assign ms_if.ms_mem_pending = (state_q == S_CANCEL);

`ifdef MS_FWD_EN
  // Forwarding to decode; blocking marks a load whose data has not arrived yet
  logic fwd_we_c;
  logic fwd_blocking_c;

  assign fwd_we_c           = ms_valid_q && gr_we;
  assign fwd_blocking_c     = ms_valid_q && mem_req && gr_we && !ms_ready_go_c;
  assign ms_if.ms_to_ds_fwd = {fwd_blocking_c, fwd_we_c, dest, final_result_c};
`endif

endmodule
